// File: rtl/bcd_disp_pkg.sv
// Shared types, 7-segment glyph constants and the BCD decode helper for the display stage.
package bcd_disp_pkg;

  typedef logic [6:0] seg7_t;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  localparam seg7_t SEG_0 = 7'b0111111;
  localparam seg7_t SEG_1 = 7'b0000110;
  localparam seg7_t SEG_2 = 7'b1011011;
  localparam seg7_t SEG_3 = 7'b1001111;
  localparam seg7_t SEG_4 = 7'b1100110;
  localparam seg7_t SEG_5 = 7'b1101101;
  localparam seg7_t SEG_6 = 7'b1111101;
  localparam seg7_t SEG_7 = 7'b0000111;
  localparam seg7_t SEG_8 = 7'b1111111;
  localparam seg7_t SEG_9 = 7'b1101111;
  localparam seg7_t SEG_E = 7'b1111001;

  function automatic seg7_t bcd_to_seg(input logic [3:0] bcd);
    seg7_t seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_seg_mux_if.sv
// Bundle between the BCD counter side and the display stage: digits, strobes and pin outputs.
interface bcd_seg_mux_if;
  import bcd_disp_pkg::*;

  logic [3:0] up;
  logic [3:0] down;
  logic       load;
  logic       blank;
  logic       clr_err;
  seg7_t      seg;
  logic [1:0] an;
  logic       err;

  modport master (
    output up, down, load, blank, clr_err,
    input  seg, an, err
  );

  modport slave (
    input  up, down, load, blank, clr_err,
    output seg, an, err
  );

endinterface

// File: rtl/refresh_tick.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and flags the terminal count for one cycle.
module refresh_tick #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic            w_tick;

  assign w_tick = (r_cnt == CntMax);
  assign o_tick = w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/bcd_seg_mux.sv
// Two-digit multiplexed 7-segment driver: shadow-captures BCD digits, rotates the active digit
// on each refresh tick and flags invalid codes.
module bcd_seg_mux
  import bcd_disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input logic          clk,
  input logic          rst,
  bcd_seg_mux_if.slave bus
);

  localparam seg7_t      SegOff = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [1:0] AnOff  = AN_ACTIVE_LOW ? 2'b11 : 2'b00;

  logic       w_tick;
  logic       r_idx;
  logic [3:0] r_shadow0;
  logic [3:0] r_shadow1;
  logic       r_err;
  seg7_t      r_seg;
  logic [1:0] r_an;

  logic [3:0] w_digit;
  seg7_t      w_seg_hi;
  seg7_t      w_seg;
  logic [1:0] w_an_hi;
  logic [1:0] w_an;
  logic       w_bad_load;

  refresh_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh_tick (
    .clk   (clk),
    .rst   (rst),
    .o_tick(w_tick)
  );

  always_comb begin
    w_digit  = r_idx ? r_shadow1 : r_shadow0;
    w_seg_hi = bcd_to_seg(w_digit);
    w_seg    = SEG_ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
    // Blank forces all anodes off; segments keep decoding so release is glitch-free.
    w_an_hi  = bus.blank ? 2'b00 : (r_idx ? 2'b10 : 2'b01);
    w_an     = AN_ACTIVE_LOW ? ~w_an_hi : w_an_hi;
    w_bad_load = bus.load && ((bus.up > 4'd9) || (bus.down > 4'd9));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= 1'b0;
    end else if (w_tick) begin
      r_idx <= ~r_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow0 <= 4'd0;
      r_shadow1 <= 4'd0;
    end else if (bus.load) begin
      r_shadow0 <= bus.up;
      r_shadow1 <= bus.down;
    end
  end

  // An invalid load on the same edge as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_bad_load) begin
      r_err <= 1'b1;
    end else if (bus.clr_err) begin
      r_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg <= SegOff;
      r_an  <= AnOff;
    end else begin
      r_seg <= w_seg;
      r_an  <= w_an;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.err = r_err;

endmodule

// File: tb/tb_bcd_seg_mux.sv
// Bench for bcd_seg_mux with REFRESH_DIV=4, active-low segments and anodes.
module tb_bcd_seg_mux;

  localparam int Div = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_seg_mux_if dif ();

  bcd_seg_mux #(
    .REFRESH_DIV   (Div),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] up;
    logic [3:0] down;
    logic       ld;
    logic       bl;
    logic       cl;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges since reset, captured digits, error flag.
  int         m_cnt;
  logic [3:0] m_sh [2];
  logic       m_err;
  logic [6:0] m_seg;
  logic [1:0] m_an;
  logic [6:0] glyph_hi [16];

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_sh[0] = 4'd0;
    m_sh[1] = 4'd0;
    m_err   = 1'b0;
  endtask

  // Drive one clock's inputs, advance the model across the edge, leave time at edge+1.
  task automatic cyc(input logic [3:0] u, input logic [3:0] d, input logic ld, input logic bl,
                     input logic cl);
    int idx;
    dif.up      = u;
    dif.down    = d;
    dif.load    = ld;
    dif.blank   = bl;
    dif.clr_err = cl;
    @(posedge clk);
    idx   = (m_cnt / Div) % 2;
    m_seg = ~glyph_hi[m_sh[idx]];
    m_an  = bl ? 2'b11 : ((idx == 0) ? 2'b10 : 2'b01);
    if (ld && (u > 9 || d > 9)) m_err = 1'b1;
    else if (cl) m_err = 1'b0;
    if (ld) begin
      m_sh[0] = u;
      m_sh[1] = d;
    end
    m_cnt++;
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_seg"}, 32'(dif.seg), 32'(m_seg));
    chk({tag, "_an"}, 32'(dif.an), 32'(m_an));
    chk({tag, "_err"}, 32'(dif.err), 32'(m_err));
  endtask

  initial begin
    glyph_hi[0]  = 7'b0111111; glyph_hi[1] = 7'b0000110; glyph_hi[2] = 7'b1011011;
    glyph_hi[3]  = 7'b1001111; glyph_hi[4] = 7'b1100110; glyph_hi[5] = 7'b1101101;
    glyph_hi[6]  = 7'b1111101; glyph_hi[7] = 7'b0000111; glyph_hi[8] = 7'b1111111;
    glyph_hi[9]  = 7'b1101111;
    for (int i = 10; i < 16; i++) glyph_hi[i] = 7'b1111001;

    tbl[0]  = '{4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 7'b1000000, 2'b10, 1'b0};
    tbl[1]  = '{4'd5, 4'd3, 1'b1, 1'b0, 1'b0, 7'b1000000, 2'b10, 1'b0};
    tbl[2]  = '{4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 7'b0010010, 2'b10, 1'b0};
    tbl[3]  = '{4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 7'b0010010, 2'b10, 1'b0};
    tbl[4]  = '{4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 7'b0110000, 2'b01, 1'b0};
    tbl[5]  = '{4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 7'b0110000, 2'b01, 1'b0};
    tbl[6]  = '{4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 7'b0110000, 2'b01, 1'b0};
    tbl[7]  = '{4'd5, 4'd3, 1'b0, 1'b0, 1'b0, 7'b0110000, 2'b01, 1'b0};
    tbl[8]  = '{4'd9, 4'd3, 1'b0, 1'b0, 1'b0, 7'b0010010, 2'b10, 1'b0};
    tbl[9]  = '{4'd9, 4'd3, 1'b1, 1'b0, 1'b0, 7'b0010010, 2'b10, 1'b0};
    tbl[10] = '{4'd9, 4'd3, 1'b0, 1'b0, 1'b0, 7'b0010000, 2'b10, 1'b0};
    tbl[11] = '{4'd9, 4'd3, 1'b0, 1'b0, 1'b0, 7'b0010000, 2'b10, 1'b0};

    dif.up = 4'd0; dif.down = 4'd0; dif.load = 1'b0; dif.blank = 1'b0; dif.clr_err = 1'b0;
    model_reset();
    #12;
    chk("rst_seg", 32'(dif.seg), 32'h7f);
    chk("rst_an", 32'(dif.an), 32'h3);
    chk("rst_err", 32'(dif.err), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Rotation, capture and hold behaviour from a fresh reset.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].up, tbl[i].down, tbl[i].ld, tbl[i].bl, tbl[i].cl);
      chk($sformatf("tbl%0d_seg", i), 32'(dif.seg), 32'(tbl[i].seg));
      chk($sformatf("tbl%0d_an", i), 32'(dif.an), 32'(tbl[i].an));
      chk($sformatf("tbl%0d_err", i), 32'(dif.err), 32'(tbl[i].err));
    end

    // Invalid load sets err; digit 0 later shows "E".
    cyc(4'hC, 4'd3, 1'b1, 1'b0, 1'b0);
    chk("err_set", 32'(dif.err), 32'h1);
    chk_model("err_set");
    for (int i = 0; i < 4; i++) begin
      cyc(4'hC, 4'd3, 1'b0, 1'b0, 1'b0);
      chk_model("err_hold");
    end
    chk("e_an", 32'(dif.an), 32'h2);
    chk("e_seg", 32'(dif.seg), 32'h06);
    cyc(4'hC, 4'd3, 1'b0, 1'b0, 1'b1);
    chk("err_clr", 32'(dif.err), 32'h0);
    cyc(4'hC, 4'd0, 1'b1, 1'b0, 1'b1);
    chk("err_set_wins", 32'(dif.err), 32'h1);
    chk_model("err_set_wins");

    // Blank holds anodes off while rotation continues underneath.
    for (int i = 0; i < 10; i++) begin
      cyc(4'd2, 4'd7, 1'b0, 1'b1, 1'b0);
      chk("blank_an", 32'(dif.an), 32'h3);
      chk_model("blank");
    end
    for (int i = 0; i < 3; i++) begin
      cyc(4'd2, 4'd7, 1'b0, 1'b0, 1'b0);
      chk_model("unblank");
    end

    // Asynchronous reset mid-slot while displaying 9 with err still set.
    cyc(4'd9, 4'd9, 1'b1, 1'b0, 1'b0);
    cyc(4'd9, 4'd9, 1'b0, 1'b0, 1'b0);
    chk_model("pre_rst");
    chk("pre_rst_seg9", 32'(dif.seg), 32'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_seg", 32'(dif.seg), 32'h7f);
    chk("arst_an", 32'(dif.an), 32'h3);
    chk("arst_err", 32'(dif.err), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc(4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_seg", 32'(dif.seg), 32'h40);
    chk("post_rst_an", 32'(dif.an), 32'h2);
    chk_model("post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      chk_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
